// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Purpose : bundles the two requester ports and the memory port of the
//           data-memory arbiter so they travel as one connection.
// Ports   : r0_* / r1_*  requester handshake, store payload and response
//           mem_*        memory address/data/op and read/write strobes
//           busy         arbiter has a transaction in flight
// Modports: slave  - arbiter side (consumes requests, drives memory port)
//           master - environment side (requesters plus memory model)
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  r0_valid;
    logic                  r0_ready;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [2:0]            r0_op;
    logic                  r0_we;
    logic                  r0_rsp_valid;
    logic [DATA_WIDTH-1:0] r0_rsp_rdata;

    logic                  r1_valid;
    logic                  r1_ready;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [2:0]            r1_op;
    logic                  r1_we;
    logic                  r1_rsp_valid;
    logic [DATA_WIDTH-1:0] r1_rsp_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic [2:0]            mem_op;
    logic                  mem_we;
    logic                  mem_rdclk;
    logic                  mem_wrclk;
    logic                  busy;

    modport slave (
        input  r0_valid, r0_addr, r0_wdata, r0_op, r0_we,
        input  r1_valid, r1_addr, r1_wdata, r1_op, r1_we,
        input  mem_dout,
        output r0_ready, r0_rsp_valid, r0_rsp_rdata,
        output r1_ready, r1_rsp_valid, r1_rsp_rdata,
        output mem_addr, mem_din, mem_op, mem_we, mem_rdclk, mem_wrclk,
        output busy
    );

    modport master (
        output r0_valid, r0_addr, r0_wdata, r0_op, r0_we,
        output r1_valid, r1_addr, r1_wdata, r1_op, r1_we,
        output mem_dout,
        input  r0_ready, r0_rsp_valid, r0_rsp_rdata,
        input  r1_ready, r1_rsp_valid, r1_rsp_rdata,
        input  mem_addr, mem_din, mem_op, mem_we, mem_rdclk, mem_wrclk,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Purpose : two-requester round-robin arbiter in front of a single-ported data
//           memory. One transaction at a time walks IDLE -> SETUP -> STROBE ->
//           HOLD -> RESP -> IDLE. Every output is a flop, so each observable
//           pulse trails the internal state by one cycle: the ready pulse shows
//           in the cycle the FSM sits in SETUP, the strobe one cycle after
//           STROBE, and the response one cycle after RESP.
// Ports   : clk_i   - clock, all state on the rising edge
//           rst_n_i - asynchronous active-low reset
//           bus_io  - requester and memory signals (slave modport)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    data_mem_arbiter_if.slave    bus_io
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  accept_s;
    logic                  grant_s;
    logic                  in_xfer_s;
    logic                  rsp_fire_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;

    // Transaction captured at acceptance; requester inputs are ignored after.
    logic                  last_grant_q, last_grant_d;
    logic                  lat_gnt_q, lat_gnt_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic [2:0]            lat_op_q, lat_op_d;
    logic                  lat_we_q, lat_we_d;

    // Output flops.
    logic                  r0_ready_q, r0_ready_d;
    logic                  r1_ready_q, r1_ready_d;
    logic                  r0_rsp_valid_q, r0_rsp_valid_d;
    logic                  r1_rsp_valid_q, r1_rsp_valid_d;
    logic [DATA_WIDTH-1:0] r0_rsp_rdata_q, r0_rsp_rdata_d;
    logic [DATA_WIDTH-1:0] r1_rsp_rdata_q, r1_rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic [2:0]            mem_op_q, mem_op_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_rdclk_q, mem_rdclk_d;
    logic                  mem_wrclk_q, mem_wrclk_d;
    logic                  busy_q, busy_d;

    // Round-robin pick: under contention favour whoever was not granted last.
    always_comb begin
        grant_s = 1'b0;
        if (bus_io.r0_valid && bus_io.r1_valid) begin
            grant_s = ~last_grant_q;
        end else if (bus_io.r1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // FSM next-state; acceptance is only possible from IDLE.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_io.r0_valid || bus_io.r1_valid) begin
                    accept_s = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Capture of the granted request and next values of all output flops.
    always_comb begin
        in_xfer_s  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
        rsp_fire_s = (state_q == S_RESP);
        // Stores answer with zero; loads return what memory shows at end of HOLD.
        rsp_data_s = lat_we_q ? {DATA_WIDTH{1'b0}} : bus_io.mem_dout;

        last_grant_d = accept_s ? grant_s : last_grant_q;
        lat_gnt_d    = accept_s ? grant_s : lat_gnt_q;
        lat_addr_d   = accept_s ? (grant_s ? bus_io.r1_addr  : bus_io.r0_addr)  : lat_addr_q;
        lat_wdata_d  = accept_s ? (grant_s ? bus_io.r1_wdata : bus_io.r0_wdata) : lat_wdata_q;
        lat_op_d     = accept_s ? (grant_s ? bus_io.r1_op    : bus_io.r0_op)    : lat_op_q;
        lat_we_d     = accept_s ? (grant_s ? bus_io.r1_we    : bus_io.r0_we)    : lat_we_q;

        r0_ready_d = accept_s & ~grant_s;
        r1_ready_d = accept_s &  grant_s;
        busy_d     = (state_q != S_IDLE);

        // Memory fields load once in SETUP and then simply hold, which keeps
        // them stable through HOLD and leaves the last values visible in IDLE.
        mem_addr_d  = (state_q == S_SETUP) ? lat_addr_q  : mem_addr_q;
        mem_din_d   = (state_q == S_SETUP) ? lat_wdata_q : mem_din_q;
        mem_op_d    = (state_q == S_SETUP) ? lat_op_q    : mem_op_q;
        mem_we_d    = in_xfer_s ? lat_we_q : 1'b0;
        // Strobes are mutually exclusive because they decode opposite lat_we_q.
        mem_rdclk_d = (state_q == S_STROBE) & ~lat_we_q;
        mem_wrclk_d = (state_q == S_STROBE) &  lat_we_q;

        r0_rsp_valid_d = rsp_fire_s & ~lat_gnt_q;
        r1_rsp_valid_d = rsp_fire_s &  lat_gnt_q;
        r0_rsp_rdata_d = r0_rsp_valid_d ? rsp_data_s : r0_rsp_rdata_q;
        r1_rsp_rdata_d = r1_rsp_valid_d ? rsp_data_s : r1_rsp_rdata_q;
    end

    // State, capture and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b1;
            lat_gnt_q      <= 1'b0;
            lat_addr_q     <= {ADDR_WIDTH{1'b0}};
            lat_wdata_q    <= {DATA_WIDTH{1'b0}};
            lat_op_q       <= 3'b000;
            lat_we_q       <= 1'b0;
            r0_ready_q     <= 1'b0;
            r1_ready_q     <= 1'b0;
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
            r0_rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            r1_rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            mem_addr_q     <= {ADDR_WIDTH{1'b0}};
            mem_din_q      <= {DATA_WIDTH{1'b0}};
            mem_op_q       <= 3'b000;
            mem_we_q       <= 1'b0;
            mem_rdclk_q    <= 1'b0;
            mem_wrclk_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            lat_gnt_q      <= lat_gnt_d;
            lat_addr_q     <= lat_addr_d;
            lat_wdata_q    <= lat_wdata_d;
            lat_op_q       <= lat_op_d;
            lat_we_q       <= lat_we_d;
            r0_ready_q     <= r0_ready_d;
            r1_ready_q     <= r1_ready_d;
            r0_rsp_valid_q <= r0_rsp_valid_d;
            r1_rsp_valid_q <= r1_rsp_valid_d;
            r0_rsp_rdata_q <= r0_rsp_rdata_d;
            r1_rsp_rdata_q <= r1_rsp_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            mem_op_q       <= mem_op_d;
            mem_we_q       <= mem_we_d;
            mem_rdclk_q    <= mem_rdclk_d;
            mem_wrclk_q    <= mem_wrclk_d;
            busy_q         <= busy_d;
        end
    end

    assign bus_io.r0_ready     = r0_ready_q;
    assign bus_io.r1_ready     = r1_ready_q;
    assign bus_io.r0_rsp_valid = r0_rsp_valid_q;
    assign bus_io.r1_rsp_valid = r1_rsp_valid_q;
    assign bus_io.r0_rsp_rdata = r0_rsp_rdata_q;
    assign bus_io.r1_rsp_rdata = r1_rsp_rdata_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_din      = mem_din_q;
    assign bus_io.mem_op       = mem_op_q;
    assign bus_io.mem_we       = mem_we_q;
    assign bus_io.mem_rdclk    = mem_rdclk_q;
    assign bus_io.mem_wrclk    = mem_wrclk_q;
    assign bus_io.busy         = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed table of single transactions, a reset-abort sequence, then a
// randomized run checked against a transaction-level reference model.
// Timeline convention: T is the cycle in which a ready pulse is visible.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int NR = 600;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory seen by the DUT, plus the model's own copy.
    logic [31:0] bmem [0:255];
    logic [31:0] model_mem [0:255];
    assign bus.mem_dout = bmem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_wrclk) bmem[bus.mem_addr[9:2]] <= bus.mem_din;
    end

    logic [31:0] mrd0, mrd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        bus.r0_we = 1'b0; bus.r1_we = 1'b0;
        bus.r0_op = 3'b000; bus.r1_op = 3'b000;
        bus.r0_addr = 32'h0; bus.r1_addr = 32'h0;
        bus.r0_wdata = 32'h0; bus.r1_wdata = 32'h0;
    endtask

    typedef struct {
        bit          v0, v1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        logic [2:0]  op0, op1;
        bit          gnt;
        logic [31:0] rdata;
    } vec_t;

    // Issue one transaction from IDLE and check its full timeline T..T+5.
    task automatic run_txn(input vec_t v);
        logic [31:0] ga, gd;
        logic [2:0]  gop;
        bit          gwe;
        ga  = v.gnt ? v.a1 : v.a0;
        gd  = v.gnt ? v.d1 : v.d0;
        gop = v.gnt ? v.op1 : v.op0;
        gwe = v.gnt ? v.we1 : v.we0;
        @(negedge clk);
        bus.r0_valid = v.v0; bus.r0_we = v.we0; bus.r0_addr = v.a0; bus.r0_wdata = v.d0; bus.r0_op = v.op0;
        bus.r1_valid = v.v1; bus.r1_we = v.we1; bus.r1_addr = v.a1; bus.r1_wdata = v.d1; bus.r1_op = v.op1;
        @(negedge clk); // T
        chk("t_ready0", bus.r0_ready, !v.gnt);
        chk("t_ready1", bus.r1_ready, v.gnt);
        chk("t_busy_T", bus.busy, 0);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        // Scramble requester inputs; memory must keep the latched values.
        bus.r0_addr = $urandom; bus.r0_wdata = $urandom; bus.r0_op = 3'($urandom);
        bus.r1_addr = $urandom; bus.r1_wdata = $urandom; bus.r1_op = 3'($urandom);
        bus.r0_we = ~v.we0; bus.r1_we = ~v.we1;
        @(negedge clk); // T+1
        chk("t_busy_T1", bus.busy, 1);
        chk("t_addr_T1", bus.mem_addr, ga);
        chk("t_din_T1", bus.mem_din, gd);
        chk("t_op_T1", bus.mem_op, gop);
        chk("t_we_T1", bus.mem_we, gwe);
        chk("t_strobes_T1", {bus.mem_rdclk, bus.mem_wrclk}, 0);
        // One-cycle pulse from the other requester while busy must be dropped.
        if (v.gnt) bus.r0_valid = 1'b1; else bus.r1_valid = 1'b1;
        @(negedge clk); // T+2
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        chk("t_rdclk_T2", bus.mem_rdclk, !gwe);
        chk("t_wrclk_T2", bus.mem_wrclk, gwe);
        chk("t_addr_T2", bus.mem_addr, ga);
        chk("t_din_T2", bus.mem_din, gd);
        chk("t_op_T2", bus.mem_op, gop);
        chk("t_we_T2", bus.mem_we, gwe);
        @(negedge clk); // T+3
        chk("t_strobes_T3", {bus.mem_rdclk, bus.mem_wrclk}, 0);
        chk("t_addr_T3", bus.mem_addr, ga);
        chk("t_we_T3", bus.mem_we, gwe);
        chk("t_ready_T3", {bus.r0_ready, bus.r1_ready}, 0);
        @(negedge clk); // T+4
        chk("t_rv0_T4", bus.r0_rsp_valid, !v.gnt);
        chk("t_rv1_T4", bus.r1_rsp_valid, v.gnt);
        if (v.gnt) mrd1 = v.rdata; else mrd0 = v.rdata;
        chk("t_rdata0_T4", bus.r0_rsp_rdata, mrd0);
        chk("t_rdata1_T4", bus.r1_rsp_rdata, mrd1);
        chk("t_we_T4", bus.mem_we, 0);
        chk("t_busy_T4", bus.busy, 1);
        @(negedge clk); // T+5
        chk("t_busy_T5", bus.busy, 0);
        chk("t_rv_T5", {bus.r0_rsp_valid, bus.r1_rsp_valid}, 0);
        chk("t_rdata0_T5", bus.r0_rsp_rdata, mrd0);
        chk("t_rdata1_T5", bus.r1_rsp_rdata, mrd1);
        chk("t_ready_T5", {bus.r0_ready, bus.r1_ready}, 0);
        if (gwe) model_mem[ga[9:2]] = gd;
        idle_inputs();
    endtask

    // Expected-event timelines for the randomized run, indexed by cycle.
    bit          e_rdy0 [0:NR+7];
    bit          e_rdy1 [0:NR+7];
    bit          e_busy [0:NR+7];
    bit          e_rd   [0:NR+7];
    bit          e_wr   [0:NR+7];
    bit          e_rv0  [0:NR+7];
    bit          e_rv1  [0:NR+7];
    bit          e_mchk [0:NR+7];
    bit          e_we   [0:NR+7];
    logic [31:0] e_addr [0:NR+7];
    logic [31:0] e_din  [0:NR+7];
    logic [2:0]  e_op   [0:NR+7];
    logic [31:0] e_rdat [0:NR+7];

    vec_t tbl [7];

    initial begin
        total = 0;
        bad   = 0;
        mrd0  = 32'h0;
        mrd1  = 32'h0;
        for (int i = 0; i < 256; i++) begin
            bmem[i]      = 32'h5A00_0000 + 32'(i);
            model_mem[i] = 32'h5A00_0000 + 32'(i);
        end
        bmem[64]      = 32'hDEAD_BEEF;
        model_mem[64] = 32'hDEAD_BEEF;

        //            v0 v1 we0 we1  a0          a1          d0            d1            op0     op1     gnt rdata
        tbl[0] = '{1, 0, 0, 0, 32'h100, 32'h0,   32'h0,        32'h0,        3'b000, 3'b000, 0, 32'hDEAD_BEEF};
        tbl[1] = '{0, 1, 0, 1, 32'h0,   32'h40,  32'h0,        32'h1234_5678, 3'b000, 3'b010, 1, 32'h0};
        tbl[2] = '{1, 0, 0, 0, 32'h40,  32'h0,   32'h0,        32'h0,        3'b011, 3'b000, 0, 32'h1234_5678};
        tbl[3] = '{1, 1, 0, 0, 32'h40,  32'h100, 32'h0,        32'h0,        3'b000, 3'b001, 1, 32'hDEAD_BEEF};
        tbl[4] = '{1, 1, 1, 0, 32'h80,  32'h40,  32'hCAFE_F00D, 32'h0,        3'b101, 3'b000, 0, 32'h0};
        tbl[5] = '{0, 1, 0, 0, 32'h0,   32'h80,  32'h0,        32'h0,        3'b000, 3'b110, 1, 32'hCAFE_F00D};
        tbl[6] = '{1, 0, 0, 0, 32'h84,  32'h0,   32'h0,        32'h0,        3'b111, 3'b000, 0, 32'h5A00_0021};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", {bus.r0_ready, bus.r1_ready}, 0);
        chk("rst_strobes", {bus.mem_rdclk, bus.mem_wrclk, bus.mem_we}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_rdata", bus.r0_rsp_rdata | bus.r1_rsp_rdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset during STROBE of a store: strobe drops at once, no response.
        @(negedge clk);
        bus.r1_valid = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'h44;
        bus.r1_wdata = 32'hBBBB_0001; bus.r1_op = 3'b001;
        @(negedge clk);
        chk("ab_ready1", bus.r1_ready, 1);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("ab_wrclk_before", bus.mem_wrclk, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ab_wrclk_after", bus.mem_wrclk, 0);
        chk("ab_busy_after", bus.busy, 0);
        chk("ab_we_after", bus.mem_we, 0);
        mrd0 = 32'h0;
        mrd1 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_rv_in_reset", {bus.r0_rsp_valid, bus.r1_rsp_valid}, 0);
        end
        rst_n = 1'b1;
        // Aborted store never reached memory; r0 wins first contention after reset.
        run_txn('{1, 1, 0, 1, 32'h44, 32'h48, 32'h0, 32'h77, 3'b000, 3'b001, 0, 32'h5A00_0011});

        // Randomized run against the transaction-level model.
        for (int i = 0; i < NR + 8; i++) begin
            e_rdy0[i] = 0; e_rdy1[i] = 0; e_busy[i] = 0; e_rd[i] = 0; e_wr[i] = 0;
            e_rv0[i] = 0; e_rv1[i] = 0; e_mchk[i] = 0; e_we[i] = 0;
            e_addr[i] = 32'h0; e_din[i] = 32'h0; e_op[i] = 3'b000; e_rdat[i] = 32'h0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mrd0 = 32'h0;
        mrd1 = 32'h0;
        begin
            int  free_at;
            bit  last;
            bit  v0, v1, g, we;
            logic [31:0] a, d;
            logic [2:0]  op;
            free_at = 0;
            last    = 1'b1;
            for (int k = 0; k < NR; k++) begin
                if (k > 0) @(negedge clk);
                chk("m_ready0", bus.r0_ready, e_rdy0[k]);
                chk("m_ready1", bus.r1_ready, e_rdy1[k]);
                chk("m_busy", bus.busy, e_busy[k]);
                chk("m_rdclk", bus.mem_rdclk, e_rd[k]);
                chk("m_wrclk", bus.mem_wrclk, e_wr[k]);
                chk("m_rv0", bus.r0_rsp_valid, e_rv0[k]);
                chk("m_rv1", bus.r1_rsp_valid, e_rv1[k]);
                if (e_rv0[k]) mrd0 = e_rdat[k];
                if (e_rv1[k]) mrd1 = e_rdat[k];
                chk("m_rdata0", bus.r0_rsp_rdata, mrd0);
                chk("m_rdata1", bus.r1_rsp_rdata, mrd1);
                chk("m_we", bus.mem_we, e_we[k]);
                if (e_mchk[k]) begin
                    chk("m_addr", bus.mem_addr, e_addr[k]);
                    chk("m_din", bus.mem_din, e_din[k]);
                    chk("m_op", bus.mem_op, e_op[k]);
                end
                // First stretch keeps both requesters asserted to show alternation.
                if (k < 30) begin
                    v0 = 1'b1; v1 = 1'b1;
                end else begin
                    v0 = ($urandom_range(0, 3) != 0);
                    v1 = ($urandom_range(0, 3) != 0);
                end
                bus.r0_valid = v0; bus.r1_valid = v1;
                bus.r0_we = 1'($urandom); bus.r1_we = 1'($urandom);
                bus.r0_addr = $urandom; bus.r1_addr = $urandom;
                bus.r0_wdata = $urandom; bus.r1_wdata = $urandom;
                bus.r0_op = 3'($urandom); bus.r1_op = 3'($urandom);
                if (k >= free_at && (v0 || v1)) begin
                    g    = (v0 && v1) ? ~last : v1;
                    last = g;
                    a    = g ? bus.r1_addr  : bus.r0_addr;
                    d    = g ? bus.r1_wdata : bus.r0_wdata;
                    op   = g ? bus.r1_op    : bus.r0_op;
                    we   = g ? bus.r1_we    : bus.r0_we;
                    if (g) e_rdy1[k+1] = 1; else e_rdy0[k+1] = 1;
                    for (int j = 2; j <= 5; j++) e_busy[k+j] = 1;
                    for (int j = 2; j <= 4; j++) begin
                        e_mchk[k+j] = 1; e_we[k+j] = we;
                        e_addr[k+j] = a; e_din[k+j] = d; e_op[k+j] = op;
                    end
                    if (we) e_wr[k+3] = 1; else e_rd[k+3] = 1;
                    if (g) e_rv1[k+5] = 1; else e_rv0[k+5] = 1;
                    e_rdat[k+5] = we ? 32'h0 : model_mem[a[9:2]];
                    if (we) model_mem[a[9:2]] = d;
                    free_at = k + 5;
                end
            end
        end
        idle_inputs();
        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
